// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture controller.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_ACTIVE = 2'd3
    } cap_state_t;

    localparam int FMT_RAW8   = 0;
    localparam int FMT_RGB565 = 1;
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/cam_sync.sv
// Multi-flop synchroniser with edge detect; q is the last sync stage, edges are
// taken against one extra registered copy of q.
module cam_sync
    import cam_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] stage [SYNC_DEPTH];
    logic [W-1:0] prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_DEPTH; i++) stage[i] <= '0;
            prev <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_DEPTH; i++) stage[i] <= stage[i-1];
            prev <= stage[SYNC_DEPTH-1];
        end
    end

    assign q    = stage[SYNC_DEPTH-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/cam_capture_ctrl.sv
// OV7670-class frame capture: xclk generation, sensor sampling in clk, pixel
// assembly and frame-buffer writes with start/continuous control and error flags.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int FORMAT   = 1,
    parameter int XCLK_DIV = 4,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_pclk,
    input  logic [7:0]        cam_data,
    output logic              cam_xclk,
    output logic              cam_reset,
    output logic              cam_pwdn,
    output logic              we,
    output logic [ADDR_W-1:0] adr,
    output logic [15:0]       dat,
    output logic              busy,
    output logic              frame_done,
    output logic              err_line,
    output logic              err_ovf
);

    localparam bit RGB = (FORMAT == FMT_RGB565);
    localparam int PW  = $clog2(H_RES + 2);
    localparam int LW  = $clog2(V_RES + 2);
    localparam logic [PW-1:0]     PIX_H     = PW'(H_RES);
    localparam logic [LW-1:0]     LINE_V    = LW'(V_RES);
    localparam logic [ADDR_W:0]   PIX_TOTAL = (ADDR_W+1)'(H_RES * V_RES);
    localparam logic [7:0]        XCLK_LAST = 8'(XCLK_DIV - 1);

    cap_state_t        state_q, state_d;
    logic              active;
    logic [2:0]        ctl_q, ctl_rise, ctl_fall;
    logic [7:0]        data_q, data_rise, data_fall;
    logic [7:0]        xclk_cnt;
    logic [ADDR_W:0]   addr_cnt;
    logic [PW-1:0]     pix_cnt;
    logic [LW-1:0]     line_cnt;
    logic              phase;
    logic [7:0]        hi_byte;
    logic              vs_rise, vs_fall, href_lvl, href_rise, href_fall, pclk_rise;

    // Control bits {vsync, href, pclk} share one synchroniser so their edges stay aligned.
    cam_sync #(.W(3)) u_sync_ctl (
        .clk  (clk),
        .rst  (rst),
        .d    ({cam_vsync, cam_href, cam_pclk}),
        .q    (ctl_q),
        .rise (ctl_rise),
        .fall (ctl_fall)
    );

    cam_sync #(.W(8)) u_sync_data (
        .clk  (clk),
        .rst  (rst),
        .d    (cam_data),
        .q    (data_q),
        .rise (data_rise),
        .fall (data_fall)
    );

    assign vs_rise   = ctl_rise[2];
    assign vs_fall   = ctl_fall[2];
    assign href_lvl  = ctl_q[1];
    assign href_rise = ctl_rise[1];
    assign href_fall = ctl_fall[1];
    assign pclk_rise = ctl_rise[0];
    assign adr       = addr_cnt[ADDR_W-1:0];
    assign cam_pwdn  = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xclk_cnt  <= '0;
            cam_xclk  <= 1'b0;
            cam_reset <= 1'b0;
        end else begin
            cam_reset <= 1'b1;
            if (xclk_cnt == XCLK_LAST) begin
                xclk_cnt <= '0;
                cam_xclk <= ~cam_xclk;
            end else begin
                xclk_cnt <= xclk_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)   state_d = ST_ARMED;
            ST_ARMED:  if (vs_rise) state_d = ST_SYNC;
            ST_SYNC:   if (vs_fall) state_d = ST_ACTIVE;
            ST_ACTIVE: if (vs_rise) state_d = continuous ? ST_SYNC : ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != ST_IDLE);
        active = (state_q == ST_ACTIVE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we         <= 1'b0;
            dat        <= '0;
            frame_done <= 1'b0;
            err_line   <= 1'b0;
            err_ovf    <= 1'b0;
            addr_cnt   <= '0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            phase      <= 1'b0;
            hi_byte    <= '0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            // adr shows the written address during the we cycle, then advances.
            if (we) addr_cnt <= addr_cnt + 1'b1;
            if (start && state_q == ST_IDLE) begin
                err_line <= 1'b0;
                err_ovf  <= 1'b0;
            end
            if (state_q == ST_SYNC && vs_fall) begin
                addr_cnt <= '0;
                pix_cnt  <= '0;
                line_cnt <= '0;
                phase    <= 1'b0;
            end
            if (active) begin
                if (pclk_rise && href_lvl) begin
                    if (RGB && !phase) begin
                        hi_byte <= data_q;
                        phase   <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
                        if (addr_cnt >= PIX_TOTAL || line_cnt >= LINE_V) begin
                            err_ovf <= 1'b1;
                        end else begin
                            we  <= 1'b1;
                            dat <= RGB ? {hi_byte, data_q} : {8'h00, data_q};
                        end
                    end
                end
                if (href_rise && line_cnt >= LINE_V) err_ovf <= 1'b1;
                // Line end: a pending high byte is dropped and flagged.
                if (href_fall) begin
                    if (pix_cnt != PIX_H || phase) err_line <= 1'b1;
                    if (line_cnt != '1) line_cnt <= line_cnt + 1'b1;
                    pix_cnt <= '0;
                    phase   <= 1'b0;
                end
                if (vs_rise) frame_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench: RGB565 and RAW8 instances driven by a behavioural sensor; writes are
// checked against a scoreboard queue, frame outcomes against a scenario table.
module tb_cam_capture_ctrl;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       sel;
    logic [1:0] st;
    logic       cont, vs, hr, pc;
    logic [7:0] dq;
    logic [1:0] vs_g, hr_g, pc_g;

    assign vs_g = {sel & vs, ~sel & vs};
    assign hr_g = {sel & hr, ~sel & hr};
    assign pc_g = {sel & pc, ~sel & pc};

    logic          xclk_o [2];
    logic          creset_o [2];
    logic          pwdn_o [2];
    logic          we_o [2];
    logic [AW-1:0] adr_o [2];
    logic [15:0]   dat_o [2];
    logic          busy_o [2];
    logic          fdone_o [2];
    logic          errl_o [2];
    logic          erro_o [2];

    cam_capture_ctrl #(.H_RES(H), .V_RES(V), .FORMAT(1), .XCLK_DIV(4), .ADDR_W(AW)) u_rgb (
        .clk(clk), .rst(rst), .start(st[0]), .continuous(cont),
        .cam_vsync(vs_g[0]), .cam_href(hr_g[0]), .cam_pclk(pc_g[0]), .cam_data(dq),
        .cam_xclk(xclk_o[0]), .cam_reset(creset_o[0]), .cam_pwdn(pwdn_o[0]),
        .we(we_o[0]), .adr(adr_o[0]), .dat(dat_o[0]), .busy(busy_o[0]),
        .frame_done(fdone_o[0]), .err_line(errl_o[0]), .err_ovf(erro_o[0])
    );

    cam_capture_ctrl #(.H_RES(H), .V_RES(V), .FORMAT(0), .XCLK_DIV(4), .ADDR_W(AW)) u_raw (
        .clk(clk), .rst(rst), .start(st[1]), .continuous(cont),
        .cam_vsync(vs_g[1]), .cam_href(hr_g[1]), .cam_pclk(pc_g[1]), .cam_data(dq),
        .cam_xclk(xclk_o[1]), .cam_reset(creset_o[1]), .cam_pwdn(pwdn_o[1]),
        .we(we_o[1]), .adr(adr_o[1]), .dat(dat_o[1]), .busy(busy_o[1]),
        .frame_done(fdone_o[1]), .err_line(errl_o[1]), .err_ovf(erro_o[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          k;
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    wr_t exp_q [$];
    int  fd_cnt;
    int  busy_drop;
    bit  busy_mon;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (we_o[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_we: dut%0d wrote adr=0x%0h dat=0x%0h, required no write", k, adr_o[k], dat_o[k]);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_dut", 32'(k), 32'(e.k));
                    check("wr_adr", 32'(adr_o[k]), 32'(e.a));
                    check("wr_dat", 32'(dat_o[k]), 32'(e.d));
                end
            end
            if (fdone_o[k] === 1'b1 && sel == k[0]) fd_cnt++;
        end
        if (busy_mon && busy_o[sel] !== 1'b1) busy_drop++;
    end

    // Sensor model state
    int m_addr, m_lines;
    bit m_off, lat_chk;

    task automatic pclk_byte(input logic [7:0] b, input bit lat);
        dq = b;
        repeat (4) @(negedge clk);
        pc = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (lat) check("we_latency", 32'(we_o[sel]), 32'(c == 3));
        end
        pc = 1'b0;
    endtask

    task automatic send_line(input int nbytes);
        logic [7:0] b, hi;
        bit ph, pushed;
        hi = 8'h00;
        ph = 1'b0;
        if (m_lines >= V) m_lines = m_lines;
        hr = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbytes; i++) begin
            b = 8'h12 + 8'(i * 34) + 8'(m_lines);
            pushed = 1'b0;
            if (sel == 1'b0 && !ph) begin
                hi = b;
                ph = 1'b1;
            end else begin
                ph = 1'b0;
                if (!m_off && m_addr < H * V && m_lines < V) begin
                    exp_q.push_back('{sel, AW'(m_addr), (sel ? {8'h00, b} : {hi, b})});
                    m_addr++;
                    pushed = 1'b1;
                end
            end
            pclk_byte(b, lat_chk && pushed);
            if (pushed) lat_chk = 1'b0;
        end
        repeat (2) @(negedge clk);
        hr = 1'b0;
        m_lines++;
        repeat (8) @(negedge clk);
    endtask

    task automatic vsync_pulse(input bit chk);
        vs = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (chk) begin
                check("frame_done_lat", 32'(fdone_o[sel]), 32'(c == 3));
                if (c == 3) check("busy_at_done", 32'(busy_o[sel]), 32'd0);
            end
        end
        vs = 1'b0;
        m_addr  = 0;
        m_lines = 0;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic k;
        logic cont;
        int   frames;
        int   lines;
        int   short_line;
        int   short_bytes;
        int   exp_fd;
        logic exp_errl;
        logic exp_erro;
    } vec_t;

    vec_t vt [6];

    initial begin
        // k  cont frames lines short  bytes  fd errl erro
        vt[0] = '{1'b0, 1'b0, 1, 2, -1, 0, 1, 1'b0, 1'b0}; // RGB565 clean frame
        vt[1] = '{1'b1, 1'b1, 3, 2, -1, 0, 3, 1'b0, 1'b0}; // RAW8 continuous x3
        vt[2] = '{1'b1, 1'b0, 1, 2,  0, 3, 1, 1'b1, 1'b0}; // RAW8 short first line
        vt[3] = '{1'b1, 1'b0, 1, 3, -1, 0, 1, 1'b0, 1'b1}; // RAW8 extra line
        vt[4] = '{1'b0, 1'b0, 1, 2,  0, 7, 1, 1'b1, 1'b0}; // RGB565 odd byte count
        vt[5] = '{1'b0, 1'b0, 1, 2, -1, 0, 1, 1'b0, 1'b0}; // errors cleared by start

        sel = 1'b0; st = 2'b00; cont = 1'b0;
        vs = 1'b0; hr = 1'b0; pc = 1'b0; dq = 8'h00;
        m_addr = 0; m_lines = 0; m_off = 1'b0; lat_chk = 1'b0;
        fd_cnt = 0; busy_drop = 0; busy_mon = 1'b0;

        repeat (10) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_xclk",   32'(xclk_o[k]),   32'd0);
            check("rst_camrst", 32'(creset_o[k]), 32'd0);
            check("rst_pwdn",   32'(pwdn_o[k]),   32'd0);
            check("rst_we",     32'(we_o[k]),     32'd0);
            check("rst_adr",    32'(adr_o[k]),    32'd0);
            check("rst_dat",    32'(dat_o[k]),    32'd0);
            check("rst_busy",   32'(busy_o[k]),   32'd0);
            check("rst_fdone",  32'(fdone_o[k]),  32'd0);
            check("rst_errl",   32'(errl_o[k]),   32'd0);
            check("rst_erro",   32'(erro_o[k]),   32'd0);
        end
        rst = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check("cam_reset", 32'(creset_o[0]), 32'd1);
            check("xclk", 32'(xclk_o[0]), 32'((c / 4) % 2));
            check("idle_busy", 32'(busy_o[0]), 32'd0);
        end

        for (int t = 0; t < 6; t++) begin
            sel = vt[t].k;
            cont = vt[t].cont;
            fd_cnt = 0;
            busy_drop = 0;
            lat_chk = (t == 0);
            st[sel] = 1'b1;
            @(negedge clk);
            st = 2'b00;
            busy_mon = 1'b1;
            vsync_pulse(1'b0);
            for (int f = 0; f < vt[t].frames; f++) begin
                if (f == vt[t].frames - 1) cont = 1'b0;
                for (int l = 0; l < vt[t].lines; l++)
                    send_line((l == vt[t].short_line) ? vt[t].short_bytes : (sel ? H : 2 * H));
                if (f == vt[t].frames - 1) busy_mon = 1'b0;
                vsync_pulse((t <= 1) && (f == vt[t].frames - 1));
            end
            check("frame_done_count", 32'(fd_cnt), 32'(vt[t].exp_fd));
            check("err_line", 32'(errl_o[sel]), 32'(vt[t].exp_errl));
            check("err_ovf", 32'(erro_o[sel]), 32'(vt[t].exp_erro));
            check("busy_held", 32'(busy_drop), 32'd0);
            check("busy_end", 32'(busy_o[sel]), 32'd0);
            check("sb_drained", 32'(exp_q.size()), 32'd0);
        end

        // Abort mid-line on the RAW8 instance
        sel = 1'b1;
        fd_cnt = 0;
        st[1] = 1'b1;
        @(negedge clk);
        st = 2'b00;
        vsync_pulse(1'b0);
        hr = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back('{1'b1, AW'(0), 16'h00A1});
        pclk_byte(8'hA1, 1'b0);
        exp_q.push_back('{1'b1, AW'(1), 16'h00A2});
        pclk_byte(8'hA2, 1'b0);
        dq = 8'hA3;
        repeat (4) @(negedge clk);
        pc = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check("abort_we", 32'(we_o[1]), 32'd0);
        end
        check("abort_busy", 32'(busy_o[1]), 32'd0);
        pc = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        m_off = 1'b1;
        send_line(H);
        vsync_pulse(1'b0);
        send_line(H);
        vsync_pulse(1'b0);
        m_off = 1'b0;
        check("post_abort_busy", 32'(busy_o[1]), 32'd0);
        check("post_abort_fdone", 32'(fd_cnt), 32'd0);
        check("post_abort_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
